mem_req_arbiter: RTL and testbench
==================================

// Module: mem_req_arbiter
// PURPOSE
//  Shares the single DDR2 request path (address FIFO, write-data FIFO, read-data FIFO) of the Memory150
//  subsystem between the instruction-cache and data-cache miss engines. Arbitrates round-robin,
//  sequences the multi-beat write/read bursts, and routes returned read beats to the granted cache.
//  Sits between the caches and the DDR2 controller, clocked on cpu_clk_g.
// PARAMETERS
//  ADDR_W   31   memory address width (word address presented to the address FIFO)
//  DATA_W   128  width of one FIFO data beat
//  BEATS    2    data beats per command (one DDR2 burst of 4 x 64b)
// PORTS
//  clk             in   1          CPU clock
//  rst             in   1          synchronous, active-high reset
//  init_done       in   1          DDR2 calibration complete; no grants while low
//  ic_req_valid    in   1          icache read request
//  ic_req_addr     in   ADDR_W     icache line address
//  ic_req_ready    out  1          1-cycle pulse: request accepted (command issued)
//  ic_resp_valid   out  1          read beat for icache
//  ic_resp_last    out  1          final beat of the burst
//  dc_req_valid    in   1          dcache request
//  dc_req_rnw      in   1          1 = read (fill), 0 = write (writeback)
//  dc_req_addr     in   ADDR_W     dcache line address
//  dc_req_ready    out  1          1-cycle pulse: request accepted
//  dc_wdata        in   DATA_W     writeback beat
//  dc_wmask        in   DATA_W/8   byte mask, 1 = byte NOT written
//  dc_wdata_valid  in   1          writeback beat valid
//  dc_wdata_ready  out  1          beat consumed this cycle
//  dc_resp_valid   out  1          read beat for dcache
//  dc_resp_last    out  1          final beat of the burst
//  resp_data       out  DATA_W     read data, shared by both caches (qualified by *_resp_valid)
//  af_wr_en        out  1          push to address FIFO
//  af_cmd          out  3          CMD_WRITE=3'b000 / CMD_READ=3'b001
//  af_addr         out  ADDR_W     command address
//  af_full         in   1          address FIFO full
//  wdf_wr_en       out  1          push to write-data FIFO
//  wdf_data        out  DATA_W     write beat
//  wdf_mask        out  DATA_W/8   write mask
//  wdf_full        in   1          write-data FIFO full
//  rdf_valid       in   1          read beat available (no back-pressure)
//  rdf_data        in   DATA_W     read beat
// BEHAVIOUR
//  Reset: state IDLE, beat counter 0, last_grant = dcache (so icache wins first tie); all outputs 0.
//  FSM: IDLE -> (grant) WR_DATA | ISSUE_RD ; WR_DATA -> ISSUE_WR ; ISSUE_WR -> IDLE ;
//       ISSUE_RD -> WAIT_RD ; WAIT_RD -> IDLE.
//  IDLE: grant only when init_done. One requester valid -> grant it. Both valid -> grant the one NOT in
//   last_grant; last_grant updated on grant. Grant registered; first command earliest next cycle.
//  WR_DATA: each cycle with dc_wdata_valid && !wdf_full: wdf_wr_en=1, dc_wdata_ready=1, count++;
//   after BEATS beats -> ISSUE_WR. Stalls indefinitely on invalid data or full FIFO.
//  ISSUE_WR: when !af_full: af_wr_en=1, af_cmd=CMD_WRITE, dc_req_ready=1 (same cycle) -> IDLE.
//   Data precedes command, as the controller requires.
//  ISSUE_RD: when !af_full: af_wr_en=1, af_cmd=CMD_READ, granted *_req_ready=1 -> WAIT_RD.
//  WAIT_RD: each rdf_valid beat forwarded combinationally: resp_data=rdf_data, granted *_resp_valid=1,
//   *_resp_last=1 on beat BEATS-1; after last beat -> IDLE. Zero added latency on responses.
//  Requesters hold valid/addr/rnw stable until ready; arbiter samples addr at ISSUE.
//  Only one command outstanding; new grant no earlier than cycle after last beat/command.
//  rdf_valid outside WAIT_RD is ignored (never routed). Requests dropping valid before ready: illegal.
//  rst mid-burst: return to IDLE next edge, counter cleared; DDR FIFOs are reset by the same
//   fifo_reset path, so no stale beats remain.
// STRUCTURE
//  Shared header mem_arb_defs: CMD_READ/CMD_WRITE encodings, FSM state encodings, BEATS default.
//  One sub-module: rr_arb2 (2-way round-robin grant with last_grant register).
//  Beat counter width $clog2(BEATS+1); datapath muxes in this module.
// TESTING
//  1 ic read alone, addr 0x100, rdf returns A,B -> af_cmd=001 addr 0x100; ic_resp A then B(last).
//  2 dc write addr 0x40, beats X,Y -> wdf X,Y pushed before af_wr_en cmd=000; dc_req_ready 1 cycle.
//  3 ic & dc read valid same cycle from reset -> ic granted first, dc next; no response cross-routing.
//  4 af_full held 10 cycles in ISSUE_RD -> no af_wr_en, no ready; issues cycle after full drops.
//  5 init_done=0 with both requests -> no grant; grant cycle after init_done rises.
//  6 rst asserted mid-WR_DATA after 1 beat -> IDLE, outputs 0; fresh write completes cleanly after.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the Memory150 request arbiter: DDR2 command encodings,
// FSM state encodings, the default burst length and requester indices.
package mem_req_arbiter_pkg;

    // Address-FIFO command encodings expected by the DDR2 controller.
    localparam logic [2:0] CmdWrite = 3'b000;
    localparam logic [2:0] CmdRead  = 3'b001;

    // Data beats per command: one DDR2 burst of 4 x 64b = 2 x 128b.
    localparam int unsigned BeatsDefault = 2;

    // Requester indices into the 2-bit request/grant vectors.
    localparam int unsigned ReqIc = 0;
    localparam int unsigned ReqDc = 1;

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StIssueWr,
        StIssueRd,
        StWaitRd
    } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of every handshake/bus signal around the request arbiter.
//   Cache side : ic_req_*, ic_resp_*, dc_req_*, dc_wdata/wmask/wdata_*, dc_resp_*, resp_data
//   DDR2 side  : af_* (address FIFO), wdf_* (write-data FIFO), rdf_* (read-data FIFO)
//   init_done  : DDR2 calibration complete
// Modport slave is the arbiter's view; modport master is the view of the caches and
// DDR2 controller surrounding it.
interface mem_req_arbiter_if #(
    parameter int unsigned AddrW = 31,
    parameter int unsigned DataW = 128
);
    logic               init_done;
    logic               ic_req_valid;
    logic [AddrW-1:0]   ic_req_addr;
    logic               ic_req_ready;
    logic               ic_resp_valid;
    logic               ic_resp_last;
    logic               dc_req_valid;
    logic               dc_req_rnw;
    logic [AddrW-1:0]   dc_req_addr;
    logic               dc_req_ready;
    logic [DataW-1:0]   dc_wdata;
    logic [DataW/8-1:0] dc_wmask;
    logic               dc_wdata_valid;
    logic               dc_wdata_ready;
    logic               dc_resp_valid;
    logic               dc_resp_last;
    logic [DataW-1:0]   resp_data;
    logic               af_wr_en;
    logic [2:0]         af_cmd;
    logic [AddrW-1:0]   af_addr;
    logic               af_full;
    logic               wdf_wr_en;
    logic [DataW-1:0]   wdf_data;
    logic [DataW/8-1:0] wdf_mask;
    logic               wdf_full;
    logic               rdf_valid;
    logic [DataW-1:0]   rdf_data;

    modport slave (
        input  init_done, ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rnw, dc_req_addr,
               dc_wdata, dc_wmask, dc_wdata_valid, af_full, wdf_full, rdf_valid, rdf_data,
        output ic_req_ready, ic_resp_valid, ic_resp_last, dc_req_ready, dc_wdata_ready,
               dc_resp_valid, dc_resp_last, resp_data, af_wr_en, af_cmd, af_addr,
               wdf_wr_en, wdf_data, wdf_mask
    );

    modport master (
        output init_done, ic_req_valid, ic_req_addr, dc_req_valid, dc_req_rnw, dc_req_addr,
               dc_wdata, dc_wmask, dc_wdata_valid, af_full, wdf_full, rdf_valid, rdf_data,
        input  ic_req_ready, ic_resp_valid, ic_resp_last, dc_req_ready, dc_wdata_ready,
               dc_resp_valid, dc_resp_last, resp_data, af_wr_en, af_cmd, af_addr,
               wdf_wr_en, wdf_data, wdf_mask
    );

endinterface

// File: rtl/mem_req_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant register.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : a grant may be issued this cycle
//   req_i[1:0]   : requests, index ReqIc / ReqDc
//   gnt_o[1:0]   : one-hot grant (combinational), all-zero when disabled or no request
module mem_req_arbiter_rr_arb2
    import mem_req_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    // 1 = dcache held the most recent grant.
    logic last_dc_q, last_dc_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                // Tie goes to whoever did not win last time.
                2'b11:   gnt_o = last_dc_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_dc_d = last_dc_q;
        if (gnt_o[ReqDc]) begin
            last_dc_d = 1'b1;
        end else if (gnt_o[ReqIc]) begin
            last_dc_d = 1'b0;
        end
    end

    // Reset to "dcache last" so the icache wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_dc_q <= 1'b1;
        end else begin
            last_dc_q <= last_dc_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares the single DDR2 request path between the icache and dcache miss engines:
// round-robin arbitration, write-burst sequencing (data before command), read command
// issue and zero-latency routing of returned read beats to the granted cache.
//   clk_i : CPU clock
//   rst_i : synchronous active-high reset; also forces all outputs low while asserted
//   bus   : mem_req_arbiter_if.slave carrying all cache and DDR2 FIFO signals
//   Beats : data beats per command
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int unsigned Beats = BeatsDefault
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_req_arbiter_if.slave  bus
);
    localparam int unsigned      CntW     = $clog2(Beats + 1);
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    arb_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            gnt_dc_q, gnt_dc_d;
    logic            arb_en;
    logic [1:0]      gnt;
    logic            beat_last;

    assign arb_en    = !rst_i && (state_q == StIdle) && bus.init_done;
    assign beat_last = (cnt_q == LastBeat);

    mem_req_arbiter_rr_arb2 u_rr_arb2 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (arb_en),
        .req_i ({bus.dc_req_valid, bus.ic_req_valid}),
        .gnt_o (gnt)
    );

    always_comb begin
        state_d            = state_q;
        cnt_d              = cnt_q;
        gnt_dc_d           = gnt_dc_q;
        bus.ic_req_ready   = 1'b0;
        bus.ic_resp_valid  = 1'b0;
        bus.ic_resp_last   = 1'b0;
        bus.dc_req_ready   = 1'b0;
        bus.dc_wdata_ready = 1'b0;
        bus.dc_resp_valid  = 1'b0;
        bus.dc_resp_last   = 1'b0;
        bus.resp_data      = '0;
        bus.af_wr_en       = 1'b0;
        bus.af_cmd         = '0;
        bus.af_addr        = '0;
        bus.wdf_wr_en      = 1'b0;
        bus.wdf_data       = '0;
        bus.wdf_mask       = '0;

        if (!rst_i) begin
            unique case (state_q)
                StIdle: begin
                    if (gnt != 2'b00) begin
                        gnt_dc_d = gnt[ReqDc];
                        state_d  = (gnt[ReqDc] && !bus.dc_req_rnw) ? StWrData : StIssueRd;
                    end
                end
                StWrData: begin
                    if (bus.dc_wdata_valid && !bus.wdf_full) begin
                        bus.wdf_wr_en      = 1'b1;
                        bus.wdf_data       = bus.dc_wdata;
                        bus.wdf_mask       = bus.dc_wmask;
                        bus.dc_wdata_ready = 1'b1;
                        if (beat_last) begin
                            cnt_d   = '0;
                            state_d = StIssueWr;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                StIssueWr: begin
                    if (!bus.af_full) begin
                        bus.af_wr_en     = 1'b1;
                        bus.af_cmd       = CmdWrite;
                        bus.af_addr      = bus.dc_req_addr;
                        bus.dc_req_ready = 1'b1;
                        state_d          = StIdle;
                    end
                end
                StIssueRd: begin
                    if (!bus.af_full) begin
                        bus.af_wr_en     = 1'b1;
                        bus.af_cmd       = CmdRead;
                        bus.af_addr      = gnt_dc_q ? bus.dc_req_addr : bus.ic_req_addr;
                        bus.dc_req_ready = gnt_dc_q;
                        bus.ic_req_ready = !gnt_dc_q;
                        state_d          = StWaitRd;
                    end
                end
                StWaitRd: begin
                    // Beats go straight through; the read FIFO cannot be stalled.
                    if (bus.rdf_valid) begin
                        bus.resp_data     = bus.rdf_data;
                        bus.dc_resp_valid = gnt_dc_q;
                        bus.dc_resp_last  = gnt_dc_q && beat_last;
                        bus.ic_resp_valid = !gnt_dc_q;
                        bus.ic_resp_last  = !gnt_dc_q && beat_last;
                        if (beat_last) begin
                            cnt_d   = '0;
                            state_d = StIdle;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            gnt_dc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_dc_q <= gnt_dc_d;
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
    localparam int unsigned AW = 31;
    localparam int unsigned DW = 128;
    localparam int unsigned NB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_req_arbiter_if #(.AddrW(AW), .DataW(DW)) bus ();

    mem_req_arbiter #(.Beats(NB)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic          ic_rdy;
        logic          dc_rdy;
    } af_exp_t;
    typedef struct {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] mask;
    } wdf_exp_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rsp_exp_t;

    af_exp_t  af_q[$];
    wdf_exp_t wdf_q[$];
    rsp_exp_t ic_q[$];
    rsp_exp_t dc_q[$];
    af_exp_t  af_e;
    wdf_exp_t wdf_e;
    rsp_exp_t rsp_e;

    int vec_cnt = 0;
    int err_cnt = 0;
    int wdf_pending = 0;

    function automatic void chk1(input string name, input logic act, input logic exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endfunction

    function automatic void chkw(input string name, input logic [DW-1:0] act,
                                 input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic outs_zero();
        return !(bus.ic_req_ready | bus.ic_resp_valid | bus.ic_resp_last | bus.dc_req_ready |
                 bus.dc_wdata_ready | bus.dc_resp_valid | bus.dc_resp_last | bus.af_wr_en |
                 bus.wdf_wr_en) && (bus.resp_data == '0) && (bus.af_cmd == '0) &&
               (bus.af_addr == '0) && (bus.wdf_data == '0) && (bus.wdf_mask == '0);
    endfunction

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.ic_req_ready;
            1:       return bus.dc_req_ready;
            default: return bus.dc_wdata_ready;
        endcase
    endfunction

    // Monitor: pops expected items whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst) begin
            wdf_pending = 0;
        end else begin
            if ((bus.ic_req_ready || bus.dc_req_ready) && !bus.af_wr_en)
                chk1("ready_without_cmd", bus.af_wr_en, 1'b1);
            if (bus.af_wr_en) begin
                if (af_q.size() == 0) begin
                    chk1("af_unexpected", bus.af_wr_en, 1'b0);
                end else begin
                    af_e = af_q.pop_front();
                    chkw("af_cmd", DW'(bus.af_cmd), DW'(af_e.cmd));
                    chkw("af_addr", DW'(bus.af_addr), DW'(af_e.addr));
                    chk1("ic_req_ready", bus.ic_req_ready, af_e.ic_rdy);
                    chk1("dc_req_ready", bus.dc_req_ready, af_e.dc_rdy);
                    if (af_e.cmd == 3'b000)
                        chkw("wdata_before_cmd", DW'(wdf_pending), DW'(NB));
                end
                wdf_pending = 0;
            end
            if (bus.wdf_wr_en) begin
                wdf_pending++;
                chk1("wdata_ready_with_push", bus.dc_wdata_ready, 1'b1);
                if (wdf_q.size() == 0) begin
                    chk1("wdf_unexpected", bus.wdf_wr_en, 1'b0);
                end else begin
                    wdf_e = wdf_q.pop_front();
                    chkw("wdf_data", bus.wdf_data, wdf_e.data);
                    chkw("wdf_mask", DW'(bus.wdf_mask), DW'(wdf_e.mask));
                end
            end
            if (bus.ic_resp_valid) begin
                chk1("resp_exclusive", bus.dc_resp_valid, 1'b0);
                if (ic_q.size() == 0) begin
                    chk1("ic_resp_unexpected", bus.ic_resp_valid, 1'b0);
                end else begin
                    rsp_e = ic_q.pop_front();
                    chkw("ic_resp_data", bus.resp_data, rsp_e.data);
                    chk1("ic_resp_last", bus.ic_resp_last, rsp_e.last);
                end
            end
            if (bus.dc_resp_valid) begin
                if (dc_q.size() == 0) begin
                    chk1("dc_resp_unexpected", bus.dc_resp_valid, 1'b0);
                end else begin
                    rsp_e = dc_q.pop_front();
                    chkw("dc_resp_data", bus.resp_data, rsp_e.data);
                    chk1("dc_resp_last", bus.dc_resp_last, rsp_e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input int which, input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (sig(which)) begin
                got = 1'b1;
                break;
            end
        end
        chk1(name, got, 1'b1);
    endtask

    task automatic push_rd(input logic dc, input logic [AW-1:0] addr,
                           input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        af_q.push_back('{3'b001, addr, !dc, dc});
        if (dc) begin
            dc_q.push_back('{b0, 1'b0});
            dc_q.push_back('{b1, 1'b1});
        end else begin
            ic_q.push_back('{b0, 1'b0});
            ic_q.push_back('{b1, 1'b1});
        end
    endtask

    // Drive two read-FIFO beats on consecutive cycles.
    task automatic beats(input logic [DW-1:0] b0, input logic [DW-1:0] b1);
        bus.rdf_valid = 1'b1;
        bus.rdf_data  = b0;
        step();
        bus.rdf_data  = b1;
        step();
        bus.rdf_valid = 1'b0;
        bus.rdf_data  = '0;
    endtask

    task automatic wr_txn(input logic [AW-1:0] addr, input logic [DW-1:0] x,
                          input logic [DW/8-1:0] mx, input logic [DW-1:0] y,
                          input logic [DW/8-1:0] my);
        wdf_q.push_back('{x, mx});
        wdf_q.push_back('{y, my});
        af_q.push_back('{3'b000, addr, 1'b0, 1'b1});
        bus.dc_req_valid   = 1'b1;
        bus.dc_req_rnw     = 1'b0;
        bus.dc_req_addr    = addr;
        bus.dc_wdata_valid = 1'b1;
        bus.dc_wdata       = x;
        bus.dc_wmask       = mx;
        wait_sig(2, "wbeat0_taken");
        step();
        bus.dc_wdata = y;
        bus.dc_wmask = my;
        wait_sig(2, "wbeat1_taken");
        step();
        bus.dc_wdata_valid = 1'b0;
        wait_sig(1, "wr_accepted");
        step();
        bus.dc_req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic bad;
        rst                = 1'b1;
        bus.init_done      = 1'b1;
        bus.ic_req_valid   = 1'b0;
        bus.ic_req_addr    = '0;
        bus.dc_req_valid   = 1'b0;
        bus.dc_req_rnw     = 1'b0;
        bus.dc_req_addr    = '0;
        bus.dc_wdata       = '0;
        bus.dc_wmask       = '0;
        bus.dc_wdata_valid = 1'b0;
        bus.af_full        = 1'b0;
        bus.wdf_full       = 1'b0;
        bus.rdf_valid      = 1'b0;
        bus.rdf_data       = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset_outputs_zero", outs_zero(), 1'b1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk1("idle_outputs_zero", outs_zero(), 1'b1);

        // 1: stray read beat in IDLE is dropped, then icache read alone.
        step();
        bus.rdf_valid = 1'b1;
        bus.rdf_data  = 128'hDEAD;
        step();
        bus.rdf_valid = 1'b0;
        push_rd(1'b0, 31'h100, 128'hA, 128'hB);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 31'h100;
        wait_sig(0, "t1_ic_accepted");
        step();
        bus.ic_req_valid = 1'b0;
        beats(128'hA, 128'hB);

        // 2: dcache writeback.
        step();
        wr_txn(31'h40, 128'h1111_2222_3333_4444, 16'h0000, 128'h5555_6666_7777_8888, 16'hF00F);

        // 3: simultaneous reads straight out of reset; icache wins the first tie.
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        push_rd(1'b0, 31'h200, 128'hC, 128'hD);
        push_rd(1'b1, 31'h300, 128'hE, 128'hF);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 31'h200;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rnw   = 1'b1;
        bus.dc_req_addr  = 31'h300;
        wait_sig(0, "t3_ic_first");
        step();
        bus.ic_req_valid = 1'b0;
        beats(128'hC, 128'hD);
        wait_sig(1, "t3_dc_second");
        step();
        bus.dc_req_valid = 1'b0;
        beats(128'hE, 128'hF);

        // 4: address FIFO full stalls ISSUE_RD.
        step();
        bus.af_full = 1'b1;
        push_rd(1'b0, 31'h180, 128'h10, 128'h11);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 31'h180;
        bad = 1'b0;
        repeat (11) begin
            @(negedge clk);
            if (bus.af_wr_en || bus.ic_req_ready) bad = 1'b1;
        end
        chk1("t4_af_full_stall", bad, 1'b0);
        step();
        bus.af_full = 1'b0;
        @(negedge clk);
        chk1("t4_issue_after_full", bus.af_wr_en & bus.ic_req_ready, 1'b1);
        step();
        bus.ic_req_valid = 1'b0;
        beats(128'h10, 128'h11);

        // 5: no grant before calibration; icache won last, so dcache wins the tie.
        step();
        bus.init_done = 1'b0;
        push_rd(1'b1, 31'h600, 128'h20, 128'h21);
        push_rd(1'b0, 31'h500, 128'h30, 128'h31);
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 31'h500;
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rnw   = 1'b1;
        bus.dc_req_addr  = 31'h600;
        bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.af_wr_en || bus.ic_req_ready || bus.dc_req_ready) bad = 1'b1;
        end
        chk1("t5_init_low_no_grant", bad, 1'b0);
        step();
        bus.init_done = 1'b1;
        @(negedge clk);
        chk1("t5_grant_cycle_no_cmd", bus.af_wr_en, 1'b0);
        @(negedge clk);
        chk1("t5_dc_issue", bus.dc_req_ready, 1'b1);
        step();
        bus.dc_req_valid = 1'b0;
        beats(128'h20, 128'h21);
        wait_sig(0, "t5_ic_after_dc");
        step();
        bus.ic_req_valid = 1'b0;
        beats(128'h30, 128'h31);

        // 6: reset after one write beat, then a clean write.
        step();
        wdf_q.push_back('{128'hAAAA, 16'h0003});
        bus.dc_req_valid   = 1'b1;
        bus.dc_req_rnw     = 1'b0;
        bus.dc_req_addr    = 31'h80;
        bus.dc_wdata_valid = 1'b1;
        bus.dc_wdata       = 128'hAAAA;
        bus.dc_wmask       = 16'h0003;
        wait_sig(2, "t6_beat0_taken");
        step();
        rst          = 1'b1;
        bus.dc_wdata = 128'hBBBB;
        @(negedge clk);
        chk1("t6_rst_outputs_zero", outs_zero(), 1'b1);
        step();
        rst              = 1'b0;
        bus.dc_req_valid = 1'b0;
        @(negedge clk);
        chk1("t6_post_rst_idle", outs_zero(), 1'b1);
        repeat (3) @(negedge clk);
        step();
        bus.dc_wdata_valid = 1'b0;
        wr_txn(31'hC0, 128'hCCCC, 16'h00F0, 128'hDDDD, 16'h8001);

        repeat (4) step();
        chkw("queues_drained", DW'(af_q.size() + wdf_q.size() + ic_q.size() + dc_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
